// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 asynchronous serial receiver. Synchronizes rx, finds the
//             falling edge of the start bit, samples mid-bit with a
//             reloadable down-counter and reports each byte or framing error
//             with a one-cycle pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int BAUDRATE = 104  // clk cycles per serial bit (115200 baud at 12 MHz)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Reload values: a full bit period, and half a period to reach mid start bit.
  localparam logic [15:0] c_reload_full = 16'(BAUDRATE - 1);
  localparam logic [15:0] c_reload_half = 16'(BAUDRATE / 2 - 1);

  logic       rx_m_q, rx_s_q, rx_p_q;
  state_t     state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       rcv_q, rcv_d;
  logic       ferr_q, ferr_d;
  logic       w_tick;

  // Sample tick: counter has run down while a frame is in progress.
  assign w_tick = (state_q != ST_IDLE) && (cnt_q == 16'd0);

  // Two-flop synchronizer plus a delayed copy of rx_s for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'h00;
      data_q   <= 8'h00;
      rcv_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      rcv_q    <= rcv_d;
      ferr_q   <= ferr_d;
    end
  end

  // Next-state logic: baud counter run-down/reload and frame sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    rcv_d    = 1'b0;
    ferr_d   = 1'b0;

    // While busy the counter free-runs, reloading a full bit after each tick.
    if (state_q != ST_IDLE) begin
      cnt_d = w_tick ? c_reload_full : cnt_q - 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        // Only a genuine 1->0 edge starts a frame; a held-low line does not.
        if (rx_p_q && !rx_s_q) begin
          state_d = ST_START;
          cnt_d   = c_reload_half;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;        // start bit did not hold: glitch
          end else begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          shreg_d  = {rx_s_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          state_d = ST_IDLE;
          if (rx_s_q) begin
            data_d = shreg_q;
            rcv_d  = 1'b1;
          end else begin
            ferr_d = 1'b1;            // byte discarded, data keeps old value
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign rcv       = rcv_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
